id_ex_stage: RTL and testbench

- ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection for the pipelined MIPS core.
- Captures decoded instruction fields and register-file operands at the end of ID.
- Drives the ALU operand, control and opcode inputs combinationally during EX.
- Inserts bubbles on load-use hazards and branch flushes.

---
 rtl/id_ex_stage_if.sv | 64 ++++++
 rtl/id_ex_stage.sv | 103 ++++++++++
 tb/tb_id_ex_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID fields and forwarding sources in, EX-side controls and operands out.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          id_valid;
    logic [5:0]    id_opcode;
    logic [4:0]    id_alu_ctl;
    logic          id_sign;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_wr_reg;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [4:0]    id_shamt;
    logic          id_alusrc1;
    logic          id_alusrc2;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          id_mem_to_reg;
    logic          flush;
    logic          mem_reg_write;
    logic [RW-1:0] mem_wr_reg;
    logic [DW-1:0] mem_result;
    logic          wb_reg_write;
    logic [RW-1:0] wb_wr_reg;
    logic [DW-1:0] wb_result;

    logic          hazard_stall;
    logic          ex_valid;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;
    logic          ex_sign;
    logic [5:0]    ex_opcode;
    logic [4:0]    ex_alu_ctl;
    logic [RW-1:0] ex_wr_reg;
    logic [DW-1:0] alu_in1;
    logic [DW-1:0] alu_in2;
    logic [DW-1:0] ex_store_data;

    modport slave (
        input  id_valid, id_opcode, id_alu_ctl, id_sign, id_rs, id_rt, id_wr_reg,
               id_rs_data, id_rt_data, id_imm, id_shamt, id_alusrc1, id_alusrc2,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, flush,
               mem_reg_write, mem_wr_reg, mem_result, wb_reg_write, wb_wr_reg, wb_result,
        output hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_sign, ex_opcode, ex_alu_ctl, ex_wr_reg,
               alu_in1, alu_in2, ex_store_data
    );

    modport master (
        output id_valid, id_opcode, id_alu_ctl, id_sign, id_rs, id_rt, id_wr_reg,
               id_rs_data, id_rt_data, id_imm, id_shamt, id_alusrc1, id_alusrc2,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, flush,
               mem_reg_write, mem_wr_reg, mem_result, wb_reg_write, wb_wr_reg, wb_result,
        input  hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_sign, ex_opcode, ex_alu_ctl, ex_wr_reg,
               alu_in1, alu_in2, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side MEM/WB operand forwarding and load-use stall generation.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          sign;
        logic          alusrc1;
        logic          alusrc2;
        logic [5:0]    opcode;
        logic [4:0]    alu_ctl;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] wr_reg;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    shamt;
    } ex_reg_t;

    ex_reg_t       ex_q, ex_d;
    logic          stall;
    logic [DW-1:0] rs_fwd, rt_fwd;

    // Load-use: the loaded value is not available until WB, so hold ID for one cycle.
    always_comb begin
        stall = ex_q.valid && ex_q.mem_read && (ex_q.wr_reg != '0) && bus.id_valid && !bus.flush
                && ((ex_q.wr_reg == bus.id_rs) || (ex_q.wr_reg == bus.id_rt));
    end

    always_comb begin
        ex_d = '0;
        if (!bus.flush && !stall && bus.id_valid) begin
            ex_d.valid      = 1'b1;
            ex_d.reg_write  = bus.id_reg_write;
            ex_d.mem_read   = bus.id_mem_read;
            ex_d.mem_write  = bus.id_mem_write;
            ex_d.mem_to_reg = bus.id_mem_to_reg;
            ex_d.sign       = bus.id_sign;
            ex_d.alusrc1    = bus.id_alusrc1;
            ex_d.alusrc2    = bus.id_alusrc2;
            ex_d.opcode     = bus.id_opcode;
            ex_d.alu_ctl    = bus.id_alu_ctl;
            ex_d.rs         = bus.id_rs;
            ex_d.rt         = bus.id_rt;
            ex_d.wr_reg     = bus.id_wr_reg;
            ex_d.rs_data    = bus.id_rs_data;
            ex_d.rt_data    = bus.id_rt_data;
            ex_d.imm        = bus.id_imm;
            ex_d.shamt      = bus.id_shamt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // MEM result is younger than WB, so it takes priority; r0 is never forwarded.
    always_comb begin
        rs_fwd = ex_q.rs_data;
        if (bus.mem_reg_write && (bus.mem_wr_reg == ex_q.rs) && (ex_q.rs != '0)) begin
            rs_fwd = bus.mem_result;
        end else if (bus.wb_reg_write && (bus.wb_wr_reg == ex_q.rs) && (ex_q.rs != '0)) begin
            rs_fwd = bus.wb_result;
        end

        rt_fwd = ex_q.rt_data;
        if (bus.mem_reg_write && (bus.mem_wr_reg == ex_q.rt) && (ex_q.rt != '0)) begin
            rt_fwd = bus.mem_result;
        end else if (bus.wb_reg_write && (bus.wb_wr_reg == ex_q.rt) && (ex_q.rt != '0)) begin
            rt_fwd = bus.wb_result;
        end
    end

    always_comb begin
        bus.hazard_stall  = stall;
        bus.ex_valid      = ex_q.valid;
        bus.ex_reg_write  = ex_q.reg_write;
        bus.ex_mem_read   = ex_q.mem_read;
        bus.ex_mem_write  = ex_q.mem_write;
        bus.ex_mem_to_reg = ex_q.mem_to_reg;
        bus.ex_sign       = ex_q.sign;
        bus.ex_opcode     = ex_q.opcode;
        bus.ex_alu_ctl    = ex_q.alu_ctl;
        bus.ex_wr_reg     = ex_q.wr_reg;
        bus.alu_in1       = ex_q.alusrc1 ? {{(DW-5){1'b0}}, ex_q.shamt} : rs_fwd;
        bus.alu_in2       = ex_q.alusrc2 ? ex_q.imm : rt_fwd;
        bus.ex_store_data = rt_fwd;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: capture, forwarding priority, load-use stall, flush, reset.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();
    id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [4:0]  alu_ctl;
        logic        sign;
        logic [4:0]  rs, rt, wr;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  shamt;
        logic        src1, src2, rw, mr, mw, m2r, flush;
        logic        mem_rw;
        logic [4:0]  mem_wr;
        logic [31:0] mem_res;
        logic        wb_rw;
        logic [4:0]  wb_wr;
        logic [31:0] wb_res;
        logic        e_stall;
        logic [5:0]  e_ctl;   // {valid, reg_write, mem_read, mem_write, mem_to_reg, sign}
        logic [5:0]  e_op;
        logic [4:0]  e_alu;
        logic [4:0]  e_wr;
        logic [31:0] e_in1, e_in2, e_st;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    endtask

    task automatic drive(input vec_t x);
        bus.id_valid      = x.valid;
        bus.id_opcode     = x.opcode;
        bus.id_alu_ctl    = x.alu_ctl;
        bus.id_sign       = x.sign;
        bus.id_rs         = x.rs;
        bus.id_rt         = x.rt;
        bus.id_wr_reg     = x.wr;
        bus.id_rs_data    = x.rs_data;
        bus.id_rt_data    = x.rt_data;
        bus.id_imm        = x.imm;
        bus.id_shamt      = x.shamt;
        bus.id_alusrc1    = x.src1;
        bus.id_alusrc2    = x.src2;
        bus.id_reg_write  = x.rw;
        bus.id_mem_read   = x.mr;
        bus.id_mem_write  = x.mw;
        bus.id_mem_to_reg = x.m2r;
        bus.flush         = x.flush;
        bus.mem_reg_write = x.mem_rw;
        bus.mem_wr_reg    = x.mem_wr;
        bus.mem_result    = x.mem_res;
        bus.wb_reg_write  = x.wb_rw;
        bus.wb_wr_reg     = x.wb_wr;
        bus.wb_result     = x.wb_res;
    endtask

    function automatic logic [5:0] ctl_now();
        return {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                bus.ex_mem_to_reg, bus.ex_sign};
    endfunction

    task automatic apply(input vec_t x, input int idx);
        drive(x);
        #1;
        chk("hazard_stall", idx, 32'(bus.hazard_stall), 32'(x.e_stall));
        @(posedge clk);
        #1;
        chk("ctl", idx, 32'(ctl_now()), 32'(x.e_ctl));
        chk("ex_opcode", idx, 32'(bus.ex_opcode), 32'(x.e_op));
        chk("ex_alu_ctl", idx, 32'(bus.ex_alu_ctl), 32'(x.e_alu));
        chk("ex_wr_reg", idx, 32'(bus.ex_wr_reg), 32'(x.e_wr));
        chk("alu_in1", idx, bus.alu_in1, x.e_in1);
        chk("alu_in2", idx, bus.alu_in2, x.e_in2);
        chk("ex_store_data", idx, bus.ex_store_data, x.e_st);
    endtask

    initial begin
        // V0: ADD r3 = r1 + r2
        v = '0; v.valid = 1; v.alu_ctl = 5'b00010; v.rs = 1; v.rs_data = 5; v.rt = 2; v.rt_data = 7;
        v.wr = 3; v.rw = 1;
        v.e_ctl = 6'b110000; v.e_alu = 5'b00010; v.e_wr = 3; v.e_in1 = 5; v.e_in2 = 7; v.e_st = 7;
        vecs.push_back(v);
        // V1: MEM beats WB on rs; rt = r0 keeps its registered data
        v = '0; v.valid = 1; v.opcode = 6'h04; v.sign = 1; v.alu_ctl = 5'b00110; v.rs = 3; v.rs_data = 32'h11;
        v.rt = 0; v.rt_data = 32'h22; v.mem_rw = 1; v.mem_wr = 3; v.mem_res = 32'h1234;
        v.wb_rw = 1; v.wb_wr = 3; v.wb_res = 32'h9999;
        v.e_ctl = 6'b100001; v.e_op = 6'h04; v.e_alu = 5'b00110; v.e_in1 = 32'h1234; v.e_in2 = 32'h22; v.e_st = 32'h22;
        vecs.push_back(v);
        // V2: MEM no longer targets r3 -> WB value
        v.mem_wr = 0; v.e_in1 = 32'h9999;
        vecs.push_back(v);
        // V3: register 0 never forwarded
        v = '0; v.valid = 1; v.alu_ctl = 5'b00010; v.rs = 0; v.rt = 5; v.rt_data = 32'h55; v.wr = 8; v.rw = 1;
        v.mem_rw = 1; v.mem_wr = 0; v.mem_res = 32'hFFFF_FFFF; v.wb_rw = 1; v.wb_wr = 0; v.wb_res = 32'hAAAA;
        v.e_ctl = 6'b110000; v.e_alu = 5'b00010; v.e_wr = 8; v.e_in1 = 0; v.e_in2 = 32'h55; v.e_st = 32'h55;
        vecs.push_back(v);
        // V4: shamt/imm selects; store data still forwarded from WB
        v = '0; v.valid = 1; v.alu_ctl = 5'b00011; v.src1 = 1; v.shamt = 5'd31; v.src2 = 1; v.imm = 32'hFFFF_FFF0;
        v.rs = 2; v.rs_data = 32'h77; v.rt = 6; v.rt_data = 32'h66; v.wr = 6; v.rw = 1;
        v.wb_rw = 1; v.wb_wr = 6; v.wb_res = 32'hCAFE;
        v.e_ctl = 6'b110000; v.e_alu = 5'b00011; v.e_wr = 6; v.e_in1 = 32'd31; v.e_in2 = 32'hFFFF_FFF0; v.e_st = 32'hCAFE;
        vecs.push_back(v);
        // V5: id_valid = 0 -> bubble
        v = '0; v.opcode = 6'h03; v.alu_ctl = 5'b00010; v.rs = 7; v.rt = 7; v.wr = 7; v.rw = 1;
        v.rs_data = 32'h99; v.rt_data = 32'h99; v.mem_rw = 1; v.mem_wr = 7; v.mem_res = 32'h1111;
        vecs.push_back(v);
        // V6: LW r4
        v = '0; v.valid = 1; v.opcode = 6'h23; v.alu_ctl = 5'b00010; v.rs = 1; v.rs_data = 32'h100;
        v.rt = 4; v.rt_data = 32'h44; v.wr = 4; v.src2 = 1; v.imm = 8; v.rw = 1; v.mr = 1; v.m2r = 1;
        v.e_ctl = 6'b111010; v.e_op = 6'h23; v.e_alu = 5'b00010; v.e_wr = 4; v.e_in1 = 32'h100; v.e_in2 = 8; v.e_st = 32'h44;
        vecs.push_back(v);
        // V7: dependent on r4 via rs -> stall, bubble
        v = '0; v.valid = 1; v.alu_ctl = 5'b00010; v.rs = 4; v.rs_data = 32'h40; v.rt = 2; v.rt_data = 7;
        v.wr = 5; v.rw = 1; v.e_stall = 1;
        vecs.push_back(v);
        // V8: same instruction re-presented; stall gone, r4 from WB
        v.e_stall = 0; v.wb_rw = 1; v.wb_wr = 4; v.wb_res = 32'hDEAD;
        v.e_ctl = 6'b110000; v.e_alu = 5'b00010; v.e_wr = 5; v.e_in1 = 32'hDEAD; v.e_in2 = 7; v.e_st = 7;
        vecs.push_back(v);
        // V9: LW r9
        v = '0; v.valid = 1; v.opcode = 6'h23; v.alu_ctl = 5'b00010; v.rt = 9; v.wr = 9; v.src2 = 1; v.imm = 4;
        v.rw = 1; v.mr = 1; v.m2r = 1;
        v.e_ctl = 6'b111010; v.e_op = 6'h23; v.e_alu = 5'b00010; v.e_wr = 9; v.e_in2 = 4;
        vecs.push_back(v);
        // V10: flush together with a load-use on r9 -> no stall, bubble
        v = '0; v.valid = 1; v.opcode = 6'h2B; v.rs = 9; v.rt = 9; v.rw = 1; v.mw = 1; v.flush = 1;
        vecs.push_back(v);
        // V11: LW r10
        v = '0; v.valid = 1; v.opcode = 6'h23; v.alu_ctl = 5'b00010; v.rs = 1; v.rs_data = 3; v.rt = 10; v.wr = 10;
        v.src2 = 1; v.rw = 1; v.mr = 1; v.m2r = 1;
        v.e_ctl = 6'b111010; v.e_op = 6'h23; v.e_alu = 5'b00010; v.e_wr = 10; v.e_in1 = 3;
        vecs.push_back(v);
        // V12: dependence through rt only -> stall
        v = '0; v.valid = 1; v.rs = 1; v.rs_data = 1; v.rt = 10; v.rt_data = 2; v.wr = 11; v.rw = 1; v.e_stall = 1;
        vecs.push_back(v);
        // V13: load targeting r0
        v = '0; v.valid = 1; v.opcode = 6'h23; v.alu_ctl = 5'b00010; v.rs = 1; v.rs_data = 3; v.src2 = 1;
        v.imm = 32'h10; v.rw = 1; v.mr = 1; v.m2r = 1;
        v.e_ctl = 6'b111010; v.e_op = 6'h23; v.e_alu = 5'b00010; v.e_in1 = 3; v.e_in2 = 32'h10;
        vecs.push_back(v);
        // V14: reader of r0 after a load to r0 -> no stall
        v = '0; v.valid = 1; v.alu_ctl = 5'b00010; v.rs_data = 5; v.rt_data = 6; v.wr = 12; v.rw = 1;
        v.e_ctl = 6'b110000; v.e_alu = 5'b00010; v.e_wr = 12; v.e_in1 = 5; v.e_in2 = 6; v.e_st = 6;
        vecs.push_back(v);

        v = '0;
        drive(v);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ctl", -1, 32'(ctl_now()), 32'h0);
        chk("rst_opcode", -1, 32'(bus.ex_opcode), 32'h0);
        chk("rst_wr_reg", -1, 32'(bus.ex_wr_reg), 32'h0);
        chk("rst_alu_in1", -1, bus.alu_in1, 32'h0);
        chk("rst_alu_in2", -1, bus.alu_in2, 32'h0);
        chk("rst_store", -1, bus.ex_store_data, 32'h0);
        chk("rst_stall", -1, 32'(bus.hazard_stall), 32'h0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset asserted while a load-use stall is pending
        apply(vecs[6], 100);
        v = vecs[7];
        drive(v);
        #1;
        chk("mid_stall_pre", 101, 32'(bus.hazard_stall), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_stall_ctl", 101, 32'(ctl_now()), 32'h0);
        chk("mid_stall_wr", 101, 32'(bus.ex_wr_reg), 32'h0);
        chk("mid_stall_post", 101, 32'(bus.hazard_stall), 32'h0);
        @(posedge clk);
        #1;
        chk("after_rst_capture", 102, 32'(bus.ex_valid), 32'h1);
        chk("after_rst_in1", 102, bus.alu_in1, 32'h40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
